// File: rtl/mult_arbiter.sv
// mult_arbiter
// Round-robin arbiter and sequencer that lets two requesters share one
// shift-add multiplier. The winning requester's operands are latched into
// o_mcand/o_mplier, o_st is pulsed for one cycle, and the product is returned
// with a one-cycle acknowledge once the multiplier reports done. A watchdog
// aborts a transaction whose done never arrives (result 0, o_err=1).
//
// Handshake: a requester raises i_reqN with stable i_aN/i_bN and holds them
// until it sees o_ackN for one cycle; it must drop i_reqN in the cycle after
// o_ackN, otherwise the still-high request is taken as a new one.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req0/1, i_a0/1, i_b0/1  requests and operands of requester 0/1
//   o_ack0/1              one-cycle completion pulse to the granted requester
//   o_result              product (0 on abort), non-zero only with an ack
//   o_err                 high with the ack when the transaction timed out
//   o_gnt                 id of the current or last granted requester
//   o_busy                high in every state except IDLE
//   o_st                  one-cycle start pulse to the multiplier control
//   o_mcand, o_mplier     operand registers feeding the multiplier datapath
//   i_mdone, i_mprod      multiplier done and product
//   o_state               debug view of the sequencer state
module mult_arbiter #(
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_req0,
  input  logic           i_req1,
  input  logic [W-1:0]   i_a0,
  input  logic [W-1:0]   i_b0,
  input  logic [W-1:0]   i_a1,
  input  logic [W-1:0]   i_b1,
  output logic           o_ack0,
  output logic           o_ack1,
  output logic [2*W-1:0] o_result,
  output logic           o_err,
  output logic           o_gnt,
  output logic           o_busy,
  output logic           o_st,
  output logic [W-1:0]   o_mcand,
  output logic [W-1:0]   o_mplier,
  input  logic           i_mdone,
  input  logic [2*W-1:0] i_mprod,
  output logic [1:0]     o_state
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_ack0;
  logic             r_ack1;
  logic [2*W-1:0]   r_result;
  logic             r_err;
  logic             r_gnt;
  logic             r_busy;
  logic             r_st;
  logic [W-1:0]     r_mcand;
  logic [W-1:0]     r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_last;
  logic             w_winner;

  // On a tie the requester that did not finish most recently wins.
  always_comb begin
    w_winner = i_req1;
    if (i_req0 && i_req1) begin
      w_winner = ~r_last;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_gnt    <= 1'b0;
      r_busy   <= 1'b0;
      r_st     <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_last   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req0 || i_req1) begin
            r_gnt    <= w_winner;
            r_mcand  <= w_winner ? i_a1 : i_a0;
            r_mplier <= w_winner ? i_b1 : i_b0;
            r_st     <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_START;
          end
        end
        S_START: begin
          r_st    <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          r_cnt <= r_cnt + CW'(1);
          // Done wins over the watchdog when both land in the same cycle.
          if (i_mdone) begin
            r_result <= i_mprod;
            r_err    <= 1'b0;
            r_ack0   <= ~r_gnt;
            r_ack1   <= r_gnt;
            r_state  <= S_RESP;
          end else if (r_cnt == LIMIT) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_ack0   <= ~r_gnt;
            r_ack1   <= r_gnt;
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          // Result and err are only meaningful alongside the ack.
          r_ack0   <= 1'b0;
          r_ack1   <= 1'b0;
          r_result <= '0;
          r_err    <= 1'b0;
          r_busy   <= 1'b0;
          r_last   <= r_gnt;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ack0   = r_ack0;
  assign o_ack1   = r_ack1;
  assign o_result = r_result;
  assign o_err    = r_err;
  assign o_gnt    = r_gnt;
  assign o_busy   = r_busy;
  assign o_st     = r_st;
  assign o_mcand  = r_mcand;
  assign o_mplier = r_mplier;
  assign o_state  = r_state;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter. Each transaction is described by its
// requests, operands and multiplier latency; the expected timeline (start
// pulse, ack cycle, result, err, grant) is derived arithmetically from those
// and compared cycle by cycle. The multiplier is modelled by the bench.
module tb_mult_arbiter;

  localparam int W       = 8;
  localparam int PW      = 2 * W;
  localparam int TIMEOUT = 8;

  logic          clk;
  logic          rst;
  logic          req0, req1;
  logic [W-1:0]  a0, b0, a1, b1;
  logic          mdone;
  logic [PW-1:0] mprod;
  logic          o_ack0, o_ack1, o_err, o_gnt, o_busy, o_st;
  logic [PW-1:0] o_result;
  logic [W-1:0]  o_mcand, o_mplier;
  logic [1:0]    o_state;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: id of last completed grant and of the last grant issued.
  logic m_last = 1'b1;
  logic m_prev_gnt = 1'b0;

  logic [PW-1:0] exp_q[$];

  mult_arbiter #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req0   (req0),
    .i_req1   (req1),
    .i_a0     (a0),
    .i_b0     (b0),
    .i_a1     (a1),
    .i_b1     (b1),
    .o_ack0   (o_ack0),
    .o_ack1   (o_ack1),
    .o_result (o_result),
    .o_err    (o_err),
    .o_gnt    (o_gnt),
    .o_busy   (o_busy),
    .o_st     (o_st),
    .o_mcand  (o_mcand),
    .o_mplier (o_mplier),
    .i_mdone  (mdone),
    .i_mprod  (mprod),
    .o_state  (o_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // One transaction. Entry: the next negedge is an IDLE cycle (cycle 0) in
  // which the requests are presented. d is the cycle count from the start
  // pulse to done; d > TIMEOUT means done never arrives. With keep=1 the
  // requests stay high after the ack so the next call is back-to-back.
  task automatic run_txn(input logic r0, input logic r1,
                         input logic [W-1:0] va0, input logic [W-1:0] vb0,
                         input logic [W-1:0] va1, input logic [W-1:0] vb1,
                         input int d, input bit keep, input bit perturb);
    logic          win;
    logic [W-1:0]  ea, eb;
    int            ack_c;
    bit            to;
    logic [PW-1:0] exp_res;
    logic [5:0]    exp_ctrl;
    logic [5:0]    got_ctrl;
    @(negedge clk);
    req0 = r0; req1 = r1;
    a0 = va0; b0 = vb0; a1 = va1; b1 = vb1;
    mdone = 1'b0;
    n_checks++;
    if ({o_busy, o_ack0, o_ack1, o_st, o_gnt} !== {4'b0000, m_prev_gnt}) begin
      n_errors++;
      $display("FAIL idle_entry: busy/ack0/ack1/st/gnt=%b expected %b",
               {o_busy, o_ack0, o_ack1, o_st, o_gnt}, {4'b0000, m_prev_gnt});
    end
    win     = (r0 && r1) ? ~m_last : r1;
    ea      = win ? va1 : va0;
    eb      = win ? vb1 : vb0;
    to      = (d > TIMEOUT);
    ack_c   = to ? TIMEOUT + 2 : d + 2;
    exp_res = to ? '0 : PW'(ea) * PW'(eb);
    exp_q.push_back(exp_res);
    for (int c = 1; c <= ack_c; c++) begin
      @(negedge clk);
      if (!to && c == d + 1) begin
        mdone = 1'b1;
        mprod = PW'(o_mcand) * PW'(o_mplier);
      end else begin
        mdone = 1'b0;
        mprod = PW'($urandom);
      end
      exp_ctrl = {c == 1, 1'b1, (c == ack_c) && !win, (c == ack_c) && win,
                  (c == ack_c) && to, win};
      got_ctrl = {o_st, o_busy, o_ack0, o_ack1, o_err, o_gnt};
      n_checks++;
      if (got_ctrl !== exp_ctrl) begin
        n_errors++;
        $display("FAIL ctrl cycle %0d: st/busy/ack0/ack1/err/gnt=%b expected %b",
                 c, got_ctrl, exp_ctrl);
      end
      n_checks++;
      if ({o_mcand, o_mplier} !== {ea, eb}) begin
        n_errors++;
        $display("FAIL operands cycle %0d: mcand=%0d mplier=%0d expected %0d %0d",
                 c, o_mcand, o_mplier, ea, eb);
      end
      n_checks++;
      if (c == ack_c) begin
        exp_res = exp_q.pop_front();
        if (o_result !== exp_res) begin
          n_errors++;
          $display("FAIL result: got %0d expected %0d", o_result, exp_res);
        end
      end else if (o_result !== '0) begin
        n_errors++;
        $display("FAIL result_idle cycle %0d: got %0d expected 0", c, o_result);
      end
      if (perturb && c == 3) begin
        a0 = W'($urandom); b0 = W'($urandom);
        a1 = W'($urandom); b1 = W'($urandom);
      end
    end
    mdone = 1'b0;
    m_last = win;
    m_prev_gnt = win;
    if (!keep) begin
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({o_busy, o_ack0, o_ack1, o_st, o_err, o_result} !== '0) begin
        n_errors++;
        $display("FAIL after_ack: busy=%b ack0=%b ack1=%b st=%b err=%b result=%0d expected all 0",
                 o_busy, o_ack0, o_ack1, o_st, o_err, o_result);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    mdone = 1'b0; mprod = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_ack0, o_ack1, o_result, o_err, o_gnt, o_busy, o_st, o_mcand, o_mplier, o_state} !== '0) begin
      n_errors++;
      $display("FAIL reset_state: ack0=%b ack1=%b result=%0d err=%b gnt=%b busy=%b st=%b mcand=%0d mplier=%0d state=%0d expected all 0",
               o_ack0, o_ack1, o_result, o_err, o_gnt, o_busy, o_st, o_mcand, o_mplier, o_state);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_busy, o_st, o_ack0, o_ack1} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_release_idle: busy/st/ack0/ack1=%b expected 0000",
               {o_busy, o_st, o_ack0, o_ack1});
    end
    m_last = 1'b1;
    m_prev_gnt = 1'b0;
  endtask

  // Both requests held high from reset release: grants must alternate 0,1,0,1.
  task automatic test_tie_fairness();
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, 1'b1, 8'd3, 8'd4, 8'd5, 8'd6, 3, i < 3, 1'b0);
    end
  endtask

  task automatic test_single();
    run_txn(1'b1, 1'b0, 8'd13, 8'd11, W'($urandom), W'($urandom), 5, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
            TIMEOUT + 5, 1'b0, 1'b0);
  endtask

  // Done on the last watchdog cycle still completes normally; one later aborts.
  task automatic test_collision();
    run_txn(1'b1, 1'b0, 8'd200, 8'd7, 8'd1, 8'd1, TIMEOUT, 1'b0, 1'b0);
    run_txn(1'b0, 1'b1, 8'd1, 8'd1, 8'd9, 8'd9, TIMEOUT + 1, 1'b0, 1'b0);
  endtask

  task automatic test_operand_stability();
    run_txn(1'b1, 1'b0, 8'd21, 8'd17, W'($urandom), W'($urandom), 6, 1'b0, 1'b1);
    run_txn(1'b0, 1'b1, W'($urandom), W'($urandom), 8'd250, 8'd3, 4, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b0;
    a0 = W'($urandom); b0 = W'($urandom);
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL busy_before_reset: busy=%b expected 1", o_busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req0 = 1'b0;
    n_checks++;
    if ({o_ack0, o_ack1, o_result, o_err, o_gnt, o_busy, o_st, o_mcand, o_mplier} !== '0) begin
      n_errors++;
      $display("FAIL mid_reset_outputs: ack0=%b ack1=%b result=%0d err=%b gnt=%b busy=%b st=%b mcand=%0d mplier=%0d expected all 0",
               o_ack0, o_ack1, o_result, o_err, o_gnt, o_busy, o_st, o_mcand, o_mplier);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_ack0, o_ack1, o_busy} !== 3'b000) begin
        n_errors++;
        $display("FAIL no_ack_after_reset cycle %0d: ack0/ack1/busy=%b expected 000",
                 i, {o_ack0, o_ack1, o_busy});
      end
    end
    m_last = 1'b1;
    m_prev_gnt = 1'b0;
    run_txn(1'b1, 1'b0, 8'd255, 8'd255, 8'd0, 8'd0, 3, 1'b0, 1'b0);
  endtask

  // Minimum latency transactions chained with requests held high.
  task automatic test_back_to_back();
    run_txn(1'b1, 1'b0, 8'd2, 8'd9, 8'd0, 8'd0, 1, 1'b1, 1'b0);
    run_txn(1'b1, 1'b1, 8'd4, 8'd5, 8'd6, 8'd7, 1, 1'b1, 1'b0);
    run_txn(1'b1, 1'b1, 8'd4, 8'd5, 8'd6, 8'd7, 1, 1'b1, 1'b0);
    run_txn(1'b0, 1'b1, 8'd0, 8'd0, 8'd128, 8'd2, 1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0] pat;
    for (int i = 0; i < 40; i++) begin
      pat = 2'($urandom_range(1, 3));
      run_txn(pat[0], pat[1], W'($urandom), W'($urandom), W'($urandom), W'($urandom),
              $urandom_range(1, TIMEOUT + 2), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_tie_fairness();
    test_single();
    test_timeout();
    test_collision();
    test_operand_stability();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one shift-add multiplier (Control unit plus its datapath) between two requesters. It latches the winning requester's operands, pulses the multiplier start, waits for the multiplier's Done, and returns the product to the granted requester with a one-cycle acknowledge. A watchdog aborts a transaction whose Done never arrives.

## Interface
- W, default 8: operand width. Product width is 2W.
- TIMEOUT, default 64: maximum number of cycles in BUSY before an abort.
- Clk  in  1: clock; all state updates on the rising edge.
- Rst  in  1: synchronous reset, active-high.
- Req0, Req1  in  1: request from requester 0/1; held high until the matching Ack.
- A0, B0, A1, B1  in  W: multiplicand/multiplier per requester; stable while Req is high.
- Ack0, Ack1  out  1: one-cycle completion pulse to the granted requester.
- Result  out  2W: product (or 0 on abort); valid only while Ack0 or Ack1 is high, 0 otherwise.
- Err  out  1: high together with Ack when the transaction timed out.
- Gnt  out  1: id of the current or last granted requester.
- Busy  out  1: high in every state other than IDLE.
- St  out  1: start pulse to the multiplier Control.
- Mcand, Mplier  out  W: operand registers driving the multiplier datapath.
- MDone  in  1: the multiplier's Done.
- MProd  in  2W: the multiplier's product.

## Operation
- States: IDLE, START, BUSY, RESP.
- **IDLE**
  - If any Req is high, grant and go to START: Gnt <= winner, Mcand <= A(winner), Mplier <= B(winner).
  - If neither Req is high, stay in IDLE.
- **Arbitration**
  - A single requester wins outright.
  - If both request, the winner is the requester not equal to Last. Last is the id of the most recently completed grant.
  - Last resets to 1, so requester 0 wins the first tie.
  - Last updates in RESP, on both normal completion and abort.
- **START**: St=1 for exactly one cycle; clear the watchdog counter; go to BUSY.
- **BUSY**
  - Counter increments every cycle.
  - If MDone is sampled high: latch MProd into the result register, Err <= 0, go to RESP.
  - Else if the counter equals TIMEOUT-1: result register <= 0, Err <= 1, go to RESP.
  - MDone has priority when both conditions hit in the same cycle.
- **RESP**: Ack(Gnt)=1 for one cycle, Result driven, Last <= Gnt; go to IDLE.
- Mcand and Mplier hold their values from the grant through RESP. They are not cleared in IDLE.
- Req, A and B of the non-granted requester are ignored until the next IDLE.
- **Requester rule**: Req must be low in the cycle after Ack. The arbiter re-samples Req in that IDLE cycle; a Req still high there is treated as a new request.
- **Reset**: Rst in any state, including mid-transaction, forces the following on the next edge:
  - state IDLE;
  - St, Ack0, Ack1, Err, Busy, Gnt = 0;
  - Result, Mcand, Mplier = 0;
  - counter = 0, Last = 1.
  - No Ack is issued for an aborted transaction. The multiplier shares Rst.

## Timing
- Cycle 0: IDLE, Req sampled high at the end of cycle 0.
- Cycle 1: START, St=1, Busy=1.
- Cycle 2 onward: BUSY.
- If MDone is first sampled high at the end of cycle d, then in cycle d+1 the state is RESP with Ack=1 and Result valid. Cycle d+2 is IDLE with Busy=0.
- Minimum request-to-Ack latency is 3 cycles (MDone high in cycle 2).
- Back-to-back throughput: the next grant is sampled in the IDLE cycle, so St pulses are at least 4 cycles apart.
- Abort: with no MDone, Ack and Err appear in cycle TIMEOUT+2 after the request was sampled.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- **Single request.** Multiplier model asserts MDone 5 cycles after St.
  - Stimulus: Req0=1, A0=8'd13, B0=8'd11.
  - Response: St at cycle 1; Ack0 at cycle 7 with Result=16'd143, Err=0; Ack1 never asserts.
- **Tie fairness.**
  - Stimulus: Req0 and Req1 both held high from reset release, with A0=3, B0=4, A1=5, B1=6.
  - Response: grants alternate 0, 1, 0, 1; Results alternate 12 and 30; no requester is granted twice in a row.
- **Timeout.**
  - Stimulus: TIMEOUT=8, model never asserts MDone, Req1=1.
  - Response: Ack1=1 with Err=1 and Result=0 exactly at cycle 10; Busy=0 at cycle 11.
- **Done/timeout collision.**
  - Stimulus: MDone first high in the same cycle the counter hits TIMEOUT-1.
  - Response: Err=0 and Result equals MProd.
- **Reset mid-operation.**
  - Stimulus: Rst=1 for one cycle while in BUSY.
  - Response: next cycle all outputs are 0 and no Ack is issued. A following Req0 with 255×255 returns Result=16'd65025.
- **Operand stability.**
  - Stimulus: change A0 and B0 after the grant, while in BUSY.
  - Response: Mcand and Mplier are unchanged, and Result reflects the operands latched at grant.
